// File: rtl/count_seq_pkg.sv
// Shared definitions for the count_seq sequencer: state encoding, width and direction codes.
// No logic, so no latency; no backpressure.
// Imported by count_step and count_seq.
package count_seq_pkg;
    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;
endpackage

// File: rtl/count_step.sv
// Combinational step unit: +1/-1 of the count, a wrap flag and a limit-equality flag.
// Zero latency (pure combinational); no backpressure.
// The step is a ripple adder with addend 01 (up) or FF (down).
module count_step
    import count_seq_pkg::*;
(
    input  logic [CNT_W-1:0] count,
    input  logic             dir,
    input  logic [CNT_W-1:0] limit_q,
    output logic [CNT_W-1:0] next,
    output logic             wrap,
    output logic             eq
);
    logic [CNT_W-1:0] addend;
    logic [CNT_W-1:0] carry;

    assign addend   = (dir == DIR_UP) ? {{(CNT_W-1){1'b0}}, 1'b1} : {CNT_W{1'b1}};
    assign carry[0] = 1'b0;

    for (genvar i = 0; i < CNT_W; i++) begin : g_fa
        assign next[i] = count[i] ^ addend[i] ^ carry[i];
        if (i < CNT_W - 1) begin : g_carry
            assign carry[i+1] = (count[i] & addend[i]) | (carry[i] & (count[i] ^ addend[i]));
        end
    end

    assign wrap = (dir & (&count)) | (~dir & ~(|count));
    assign eq   = ~(|(count ^ limit_q));
endmodule

// File: rtl/count_seq.sv
// Bounded up/down counter sequencer with start/busy/done handshake and tc/ovf pulses.
// All outputs registered: busy one edge after start, first step the edge after that.
// No backpressure; en gates stepping during RUN, stop aborts.
module count_seq
    import count_seq_pkg::*;
#(
    parameter int             WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = 8'h00
) (
    input  logic             clk,
    input  logic             res,
    input  logic             start,
    input  logic             stop,
    input  logic             en,
    input  logic             up,
    input  logic             load_en,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             tc,
    output logic             ovf
);
    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] limit_q, limit_d;
    logic             dir_q, dir_d;
    logic             busy_q, done_q, tc_q, ovf_q;
    logic             tc_d, ovf_d;
    logic [WIDTH-1:0] step_next;
    logic             step_wrap, step_eq;

    count_step u_step (
        .count   (count_q),
        .dir     (dir_q),
        .limit_q (limit_q),
        .next    (step_next),
        .wrap    (step_wrap),
        .eq      (step_eq)
    );

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        limit_d = limit_q;
        dir_d   = dir_q;
        tc_d    = 1'b0;
        ovf_d   = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (load_en) begin
                    count_d = load_val;
                end
                if (start) begin
                    state_d = ST_RUN;
                    limit_d = limit;
                    dir_d   = up;
                end else if (load_en) begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                // Limit is compared against the pre-step count.
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (en) begin
                    if (step_eq) begin
                        state_d = ST_DONE;
                        tc_d    = 1'b1;
                    end else begin
                        count_d = step_next;
                        ovf_d   = step_wrap;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (res) begin
            state_q <= ST_IDLE;
            count_q <= RESET_VAL;
            limit_q <= '0;
            dir_q   <= DIR_UP;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            tc_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            limit_q <= limit_d;
            dir_q   <= dir_d;
            busy_q  <= (state_d == ST_RUN);
            done_q  <= (state_d == ST_DONE);
            tc_q    <= tc_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count = count_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign tc    = tc_q;
    assign ovf   = ovf_q;
endmodule
